// File: rtl/sample_framer.sv
// Double-buffered capture of a continuous sample stream into N-sample frames
// for the FFT. Drives the write side of the FFT start/done handshake.
module sample_framer #(
    parameter int WIDTH = 12,
    parameter int N     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_valid,
    input  logic [WIDTH-1:0]       sample_in,
    input  logic                   fft_done,
    output logic                   fft_start,
    output logic [WIDTH-1:0]       time_samples [0:N-1],
    output logic [$clog2(N)-1:0]   fill_count,
    output logic                   overrun,
    output logic [7:0]             dropped_frames
);

    localparam int PW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WIDTH-1:0] bank0 [0:N-1];
    logic [WIDTH-1:0] bank1 [0:N-1];
    logic            rd_sel;
    logic [PW-1:0]   wr_ptr;
    logic            frame_done;
    logic            accept;
    logic            drop;

    always_comb begin
        frame_done = sample_valid && (wr_ptr == PW'(N - 1));
        accept     = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (frame_done) begin
                    accept     = 1'b1;
                    state_next = START;
                end
            end
            START: state_next = WAIT;
            WAIT: begin
                // A completion coinciding with fft_done is taken, not dropped
                if (fft_done) begin
                    if (frame_done) begin
                        accept     = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        drop = frame_done && !accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rd_sel         <= 1'b0;
            wr_ptr         <= '0;
            overrun        <= 1'b0;
            dropped_frames <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                bank0[i] <= '0;
                bank1[i] <= '0;
            end
        end else begin
            state   <= state_next;
            overrun <= drop;
            if (drop && dropped_frames != 8'hFF)
                dropped_frames <= dropped_frames + 8'd1;
            // The write bank is always the one not selected for reading
            if (sample_valid) begin
                if (rd_sel)
                    bank0[wr_ptr] <= sample_in;
                else
                    bank1[wr_ptr] <= sample_in;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (accept)
                rd_sel <= ~rd_sel;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N; i++)
            time_samples[i] = rd_sel ? bank1[i] : bank0[i];
    end

    assign fft_start  = (state == START);
    assign fill_count = wr_ptr;

endmodule
